// File: rtl/program_counter_unit.sv
// Program counter with fixed-priority next-PC selection and a circular
// return-address stack (RAS) that overwrites its oldest entry when full.
module program_counter_unit #(
    parameter int                 WIDTH        = 32,
    parameter int                 INC          = 4,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0]   EXC_VECTOR   = WIDTH'(32'h0000_0080),
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Stall,
    input  logic             Branch,
    input  logic [WIDTH-1:0] BranchTarget,
    input  logic             Jump,
    input  logic             Call,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             Ret,
    input  logic             Exception,
    output logic [WIDTH-1:0] PCResult,
    output logic [WIDTH-1:0] PCPlusInc,
    output logic             RasEmpty,
    output logic             RasFull,
    output logic             RasUnderflow
);

    localparam int                 PTR_W    = $clog2(RAS_DEPTH);
    localparam int                 CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(RAS_DEPTH);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;          // next write slot; top of stack is r_ptr-1
    logic [CNT_W-1:0] r_count;
    logic             r_empty;
    logic             r_full;
    logic             r_underflow;

    logic [WIDTH-1:0] w_pc_plus_inc;
    logic [WIDTH-1:0] w_next_pc;
    logic [PTR_W-1:0] w_top_idx;
    logic [PTR_W-1:0] w_next_ptr;
    logic [CNT_W-1:0] w_next_count;
    logic             w_push;
    logic             w_pop;
    logic             w_underflow;

    assign w_pc_plus_inc = r_pc + WIDTH'(INC);
    assign w_top_idx     = r_ptr - PTR_W'(1);

    // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_pc   = w_pc_plus_inc;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_underflow = 1'b0;
        if (Exception) begin
            w_next_pc = EXC_VECTOR;
        end else if (Stall) begin
            w_next_pc = r_pc;
        end else if (Ret) begin
            if (r_count != '0) begin
                w_next_pc = r_ras[w_top_idx];
                w_pop     = 1'b1;
            end else begin
                w_next_pc   = JumpTarget;
                w_underflow = 1'b1;
            end
        end else if (Call) begin
            w_next_pc = JumpTarget;
            w_push    = 1'b1;
        end else if (Jump) begin
            w_next_pc = JumpTarget;
        end else if (Branch) begin
            w_next_pc = BranchTarget;
        end
    end

    // A push into a full stack lands on the oldest slot, so the count saturates.
    always_comb begin
        w_next_ptr   = r_ptr;
        w_next_count = r_count;
        if (Exception) begin
            w_next_ptr   = '0;
            w_next_count = '0;
        end else if (w_push) begin
            w_next_ptr   = r_ptr + PTR_W'(1);
            w_next_count = (r_count == FULL_CNT) ? r_count : r_count + CNT_W'(1);
        end else if (w_pop) begin
            w_next_ptr   = w_top_idx;
            w_next_count = r_count - CNT_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pc        <= RESET_VECTOR;
            r_ptr       <= '0;
            r_count     <= '0;
            r_empty     <= 1'b1;
            r_full      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_next_pc;
            r_ptr       <= w_next_ptr;
            r_count     <= w_next_count;
            r_empty     <= (w_next_count == '0);
            r_full      <= (w_next_count == FULL_CNT);
            r_underflow <= w_underflow;
        end
    end

    // NOTE: stack storage has no reset; entries are only read below a count that reset clears.
    always_ff @(posedge Clk) begin
        if (w_push && !Reset) begin
            r_ras[r_ptr] <= w_pc_plus_inc;
        end
    end

    assign PCResult     = r_pc;
    assign PCPlusInc    = w_pc_plus_inc;
    assign RasEmpty     = r_empty;
    assign RasFull      = r_full;
    assign RasUnderflow = r_underflow;

endmodule

// File: tb/tb_program_counter_unit.sv
// Testbench for program_counter_unit: directed vector table, hand-written
// reset/wrap/exception sequences, then random stimulus against a queue model.
module tb_program_counter_unit;

    localparam logic [31:0] EXC = 32'h0000_0080;
    localparam logic [5:0]  B = 6'd1, J = 6'd2, C = 6'd4, R = 6'd8, S = 6'd16, E = 6'd32;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, branch, jump, call, ret, exc;
    logic [31:0] bt, jt;
    logic [31:0] pc, pcp;
    logic        empty, full, uf;

    logic        b_stall, b_branch, b_jump, b_call, b_ret, b_exc;
    logic [7:0]  b_bt, b_jt, b_pc, b_pcp;
    logic        b_empty, b_full, b_uf;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    program_counter_unit dut (
        .Clk(clk), .Reset(rst), .Stall(stall), .Branch(branch), .BranchTarget(bt),
        .Jump(jump), .Call(call), .JumpTarget(jt), .Ret(ret), .Exception(exc),
        .PCResult(pc), .PCPlusInc(pcp), .RasEmpty(empty), .RasFull(full),
        .RasUnderflow(uf)
    );

    program_counter_unit #(.WIDTH(8), .INC(4), .RESET_VECTOR(8'h00),
                           .EXC_VECTOR(8'h80), .RAS_DEPTH(4)) dut8 (
        .Clk(clk), .Reset(rst), .Stall(b_stall), .Branch(b_branch), .BranchTarget(b_bt),
        .Jump(b_jump), .Call(b_call), .JumpTarget(b_jt), .Ret(b_ret), .Exception(b_exc),
        .PCResult(b_pc), .PCPlusInc(b_pcp), .RasEmpty(b_empty), .RasFull(b_full),
        .RasUnderflow(b_uf)
    );

    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] bt;
        logic [31:0] jt;
        logic [31:0] exp_pc;
        logic        exp_empty;
        logic        exp_full;
        logic        exp_uf;
    } vec_t;

    vec_t vecs[$];

    // Behavioural reference: the stack is a plain queue, newest at the back.
    logic [31:0] m_pc;
    logic [31:0] m_ras[$];
    logic        m_uf;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        {stall, branch, jump, call, ret, exc} = '0;
        bt = '0;
        jt = '0;
        {b_stall, b_branch, b_jump, b_call, b_ret, b_exc} = '0;
        b_bt = '0;
        b_jt = '0;
    endtask

    task automatic drive_ctl(input logic [5:0] ctl);
        branch = ctl[0];
        jump   = ctl[1];
        call   = ctl[2];
        ret    = ctl[3];
        stall  = ctl[4];
        exc    = ctl[5];
    endtask

    function automatic vec_t v(input logic [5:0] ctl, input logic [31:0] vbt, input logic [31:0] vjt,
                               input logic [31:0] epc, input logic ee, input logic ef, input logic eu);
        vec_t r;
        r.ctl = ctl; r.bt = vbt; r.jt = vjt;
        r.exp_pc = epc; r.exp_empty = ee; r.exp_full = ef; r.exp_uf = eu;
        return r;
    endfunction

    task automatic model_reset();
        m_pc = 32'h0;
        m_ras.delete();
        m_uf = 1'b0;
    endtask

    task automatic model_step();
        m_uf = 1'b0;
        if (exc) begin
            m_pc = EXC;
            m_ras.delete();
        end else if (stall) begin
            m_pc = m_pc;
        end else if (ret) begin
            if (m_ras.size() > 0) m_pc = m_ras.pop_back();
            else begin
                m_pc = jt;
                m_uf = 1'b1;
            end
        end else if (call) begin
            m_ras.push_back(m_pc + 32'd4);
            if (m_ras.size() > 4) void'(m_ras.pop_front());
            m_pc = jt;
        end else if (jump) begin
            m_pc = jt;
        end else if (branch) begin
            m_pc = bt;
        end else begin
            m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        #12;
        check("reset_pc", pc, 32'h0);
        check("reset_pcplusinc", pcp, 32'h4);
        check("reset_empty", empty, 1'b1);
        check("reset_full", full, 1'b0);
        check("reset_underflow", uf, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Sequential, priority, RAS, overflow/underflow, Ret+Call, Jump+Call, exception.
        vecs.push_back(v(0, 0, 0, 32'h04, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h08, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h0C, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h10, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, 32'h14, 1, 0, 0));
        vecs.push_back(v(B, 32'h40, 0, 32'h40, 1, 0, 0));
        vecs.push_back(v(B | J, 32'h100, 32'h200, 32'h200, 1, 0, 0));
        vecs.push_back(v(S | B, 32'h100, 0, 32'h200, 1, 0, 0));
        vecs.push_back(v(J, 0, 32'h10, 32'h10, 1, 0, 0));
        vecs.push_back(v(C, 0, 32'h20, 32'h20, 0, 0, 0));
        vecs.push_back(v(C, 0, 32'h30, 32'h30, 0, 0, 0));
        vecs.push_back(v(C, 0, 32'h40, 32'h40, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'h34, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'h24, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'h14, 1, 0, 0));
        vecs.push_back(v(C, 0, 32'h100, 32'h100, 0, 0, 0));
        vecs.push_back(v(C, 0, 32'h200, 32'h200, 0, 0, 0));
        vecs.push_back(v(C, 0, 32'h300, 32'h300, 0, 0, 0));
        vecs.push_back(v(C, 0, 32'h400, 32'h400, 0, 1, 0));
        vecs.push_back(v(C, 0, 32'h500, 32'h500, 0, 1, 0));
        vecs.push_back(v(R, 0, 0, 32'h404, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'h304, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'h204, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'h104, 1, 0, 0));
        vecs.push_back(v(R, 0, 32'h900, 32'h900, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 32'h904, 1, 0, 0));
        vecs.push_back(v(C | R, 0, 32'hA00, 32'hA00, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 32'hA04, 1, 0, 0));
        vecs.push_back(v(J | C, 0, 32'hB00, 32'hB00, 0, 0, 0));
        vecs.push_back(v(S | R, 0, 32'h111, 32'hB00, 0, 0, 0));
        vecs.push_back(v(R, 0, 0, 32'hA08, 1, 0, 0));
        vecs.push_back(v(C, 0, 32'hC00, 32'hC00, 0, 0, 0));
        vecs.push_back(v(E | S | C, 0, 32'hD00, EXC, 1, 0, 0));
        vecs.push_back(v(0, 0, 0, EXC + 32'h4, 1, 0, 0));

        foreach (vecs[i]) begin
            drive_ctl(vecs[i].ctl);
            bt = vecs[i].bt;
            jt = vecs[i].jt;
            tick();
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
            check($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
            check($sformatf("vec%0d_underflow", i), uf, vecs[i].exp_uf);
        end

        // Asynchronous reset between edges in the middle of a call sequence.
        idle_inputs();
        call = 1'b1; jt = 32'h300; tick();
        jt = 32'h400; tick();
        check("async_pre_empty", empty, 1'b0);
        jt = 32'h500;
        #3 rst = 1'b1;
        #1;
        check("async_pc", pc, 32'h0);
        check("async_empty", empty, 1'b1);
        check("async_full", full, 1'b0);
        idle_inputs();
        #1 rst = 1'b0;
        tick();
        check("post_reset_pc", pc, 32'h4);
        check("post_reset_empty", empty, 1'b1);
        ret = 1'b1; jt = 32'h777; tick();
        check("post_reset_ret_pc", pc, 32'h777);
        check("post_reset_ret_underflow", uf, 1'b1);
        idle_inputs(); tick();
        check("underflow_pulse_end", uf, 1'b0);
        check("after_underflow_pc", pc, 32'h77B);

        // 8-bit instance: wraparound and exception overriding stall.
        b_jump = 1'b1; b_jt = 8'hFC; tick();
        check("w8_jump_pc", b_pc, 8'hFC);
        check("w8_pcplusinc_wrap", b_pcp, 8'h00);
        b_jump = 1'b0; tick();
        check("w8_wrap_pc", b_pc, 8'h00);
        b_call = 1'b1; b_jt = 8'h10; tick();
        check("w8_call1_pc", b_pc, 8'h10);
        b_jt = 8'h20; tick();
        check("w8_call2_empty", b_empty, 1'b0);
        b_call = 1'b0; b_exc = 1'b1; b_stall = 1'b1; b_ret = 1'b1; tick();
        check("w8_exc_pc", b_pc, 8'h80);
        check("w8_exc_empty", b_empty, 1'b1);
        idle_inputs();

        // Random stimulus against the queue model.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 400; k++) begin
            exc    = ($urandom_range(0, 24) == 0);
            stall  = ($urandom_range(0, 5) == 0);
            ret    = ($urandom_range(0, 3) == 0);
            call   = ($urandom_range(0, 3) == 0);
            jump   = ($urandom_range(0, 5) == 0);
            branch = ($urandom_range(0, 2) == 0);
            bt     = $urandom;
            jt     = $urandom;
            tick();
            model_step();
            check($sformatf("rnd%0d_pc", k), pc, m_pc);
            check($sformatf("rnd%0d_pcplusinc", k), pcp, m_pc + 32'd4);
            check($sformatf("rnd%0d_empty", k), empty, m_ras.size() == 0);
            check($sformatf("rnd%0d_full", k), full, m_ras.size() == 4);
            check($sformatf("rnd%0d_underflow", k), uf, m_uf);
        end
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/program_counter_unit.md
PROGRAM_COUNTER_UNIT -- requirements
Module: program_counter_unit

Interface
REQ-001 SHALL expose parameter WIDTH, default 32, PC and target width in bits.
REQ-002 SHALL expose parameter INC, default 4, sequential increment in bytes.
REQ-003 SHALL expose parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 SHALL expose parameter EXC_VECTOR, default 32'h0000_0080, PC value loaded on exception.
REQ-005 SHALL expose parameter RAS_DEPTH, default 4 (power of two, 2..16), return-address-stack entries.
REQ-006 SHALL have port Clk  input  1  single system clock, all state updates on rising edge.
REQ-007 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port Stall  input  1  hold PC and RAS this cycle.
REQ-009 SHALL have port Branch  input  1  take BranchTarget.
REQ-010 SHALL have port BranchTarget  input  WIDTH  branch destination.
REQ-011 SHALL have port Jump  input  1  take JumpTarget.
REQ-012 SHALL have port Call  input  1  take JumpTarget and push return address.
REQ-013 SHALL have port JumpTarget  input  WIDTH  jump/call destination; return fallback.
REQ-014 SHALL have port Ret  input  1  pop RAS into PC.
REQ-015 SHALL have port Exception  input  1  redirect to EXC_VECTOR.
REQ-016 SHALL have port PCResult  output  WIDTH  registered current PC.
REQ-017 SHALL have port PCPlusInc  output  WIDTH  combinational PCResult+INC, mod 2^WIDTH.
REQ-018 SHALL have port RasEmpty  output  1  registered, RAS holds no entries.
REQ-019 SHALL have port RasFull  output  1  registered, RAS holds RAS_DEPTH entries.
REQ-020 SHALL have port RasUnderflow  output  1  registered one-cycle pulse: Ret taken with empty RAS.

Function
REQ-021 SHALL select next PC by fixed priority: Exception > Stall(hold) > Ret > Call/Jump > Branch > PCResult+INC.
REQ-022 SHALL update PCResult one cycle after the selecting inputs are sampled (latency 1).
REQ-023 SHALL compute PCResult+INC modulo 2^WIDTH; all-ones-region wrap to low addresses, no flag.
REQ-024 SHALL, on Exception, load EXC_VECTOR, flush RAS to empty, ignore Stall and all other controls.
REQ-025 SHALL, on Stall without Exception, hold PCResult, RAS contents, count; RasUnderflow low.
REQ-026 SHALL, on Call, load JumpTarget and push PCResult+INC onto RAS.
REQ-027 SHALL, on push while full, overwrite oldest entry (circular), count stays RAS_DEPTH.
REQ-028 SHALL, on Ret with RAS non-empty, load top entry and decrement count.
REQ-029 SHALL, on Ret with RAS empty, load JumpTarget, leave count 0, pulse RasUnderflow for one cycle.
REQ-030 SHALL, on Ret and Call same cycle, perform Ret only; no push.
REQ-031 SHALL treat Jump and Call same cycle as Call.
REQ-032 SHALL not pass targets through alignment logic; low bits loaded verbatim.

Reset
REQ-033 SHALL, while Reset high, asynchronously force PCResult=RESET_VECTOR, RAS count 0, RasEmpty=1, RasFull=0, RasUnderflow=0.
REQ-034 SHALL, on Reset mid-operation, discard pending push/pop; first post-reset edge with no controls yields RESET_VECTOR+INC.
REQ-035 SHALL not require RAS entry storage to be cleared by reset; entries unreadable until pushed.

Verification
REQ-036 SHALL cover sequential: reset released, 5 idle edges -> PCResult 0,4,8,12,16,20.
REQ-037 SHALL cover priority: at PC=0x40, Branch=1 (0x100) + Jump=1 (0x200) -> PC 0x200; next cycle Stall=1 + Branch=1 -> PC stays 0x200.
REQ-038 SHALL cover RAS: Calls at PC 0x10,0x20,0x30 (targets 0x20,0x30,0x40) then 3 Rets -> PC 0x34,0x24,0x14, RasEmpty=1 after third.
REQ-039 SHALL cover overflow/underflow: 5 Calls with RAS_DEPTH=4 -> RasFull=1, 4 Rets return newest four, 5th Ret with JumpTarget=0x900 -> PC 0x900, RasUnderflow one-cycle pulse.
REQ-040 SHALL cover exception/wrap: WIDTH=8 PC=0xFC idle -> 0x00; Exception with Stall=1 and 2 RAS entries -> PC EXC_VECTOR[7:0]=0x80, RasEmpty=1.
REQ-041 SHALL cover async reset: Reset asserted between edges mid-Call sequence -> PCResult=RESET_VECTOR immediately, RasEmpty=1 before next edge.
